// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings and FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_LTS = 5'd8;
  localparam logic [4:0] ALU_LTU = 5'd9;
  localparam logic [4:0] ALU_GES = 5'd10;
  localparam logic [4:0] ALU_GEU = 5'd11;
  localparam logic [4:0] ALU_EQ  = 5'd12;
  localparam logic [4:0] ALU_NE  = 5'd13;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_grant_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the CSR/debug unit (port 1).
//  state    | meaning
//  ARB_IDLE | waiting for a command, grant decided combinationally
//  ARB_EXEC | operands registered onto the ALU, result captured at the edge
//  ARB_RESP | response presented to the owner until it is consumed
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            r0_valid_i,
  output logic            r0_ready_o,
  input  logic [OP_W-1:0] r0_op_i,
  input  logic [XLEN-1:0] r0_a_i,
  input  logic [XLEN-1:0] r0_b_i,
  output logic            r0_rsp_valid_o,
  input  logic            r0_rsp_ready_i,
  output logic [XLEN-1:0] r0_result_o,
  output logic            r0_flag_o,
  input  logic            r1_valid_i,
  output logic            r1_ready_o,
  input  logic [OP_W-1:0] r1_op_i,
  input  logic [XLEN-1:0] r1_a_i,
  input  logic [XLEN-1:0] r1_b_i,
  output logic            r1_rsp_valid_o,
  input  logic            r1_rsp_ready_i,
  output logic [XLEN-1:0] r1_result_o,
  output logic            r1_flag_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [OP_W-1:0] alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_flag_i,
  output logic            busy_o
);

  arb_state_e      state_q;
  logic            last_grant_q;
  logic            owner_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] res0_q, res1_q;
  logic            flag0_q, flag1_q;
  logic            rsp0_q, rsp1_q;
  logic [1:0]      gnt;

  rr_arbiter2 u_rr (
    .req_i        ({r1_valid_i, r0_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign r0_ready_o     = (state_q == ARB_IDLE) && gnt[0];
  assign r1_ready_o     = (state_q == ARB_IDLE) && gnt[1];
  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_op_o       = op_q;
  assign r0_rsp_valid_o = rsp0_q;
  assign r1_rsp_valid_o = rsp1_q;
  assign r0_result_o    = res0_q;
  assign r1_result_o    = res1_q;
  assign r0_flag_o      = flag0_q;
  assign r1_flag_o      = flag1_q;
  assign busy_o         = (state_q != ARB_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      flag0_q      <= 1'b0;
      flag1_q      <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (r0_valid_i && r0_ready_o) begin
            op_q    <= r0_op_i;
            a_q     <= r0_a_i;
            b_q     <= r0_b_i;
            owner_q <= 1'b0;
            state_q <= ARB_EXEC;
          end else if (r1_valid_i && r1_ready_o) begin
            op_q    <= r1_op_i;
            a_q     <= r1_a_i;
            b_q     <= r1_b_i;
            owner_q <= 1'b1;
            state_q <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          if (owner_q) begin
            res1_q  <= alu_result_i;
            flag1_q <= alu_flag_i;
            rsp1_q  <= 1'b1;
          end else begin
            res0_q  <= alu_result_i;
            flag0_q <= alu_flag_i;
            rsp0_q  <= 1'b1;
          end
          state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          if ((rsp0_q && r0_rsp_ready_i) || (rsp1_q && r1_rsp_ready_i)) begin
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int OP_W = 5;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            r0_valid_i, r0_ready_o, r0_rsp_valid_o, r0_rsp_ready_i, r0_flag_o;
  logic [OP_W-1:0] r0_op_i;
  logic [XLEN-1:0] r0_a_i, r0_b_i, r0_result_o;
  logic            r1_valid_i, r1_ready_o, r1_rsp_valid_o, r1_rsp_ready_i, r1_flag_o;
  logic [OP_W-1:0] r1_op_i;
  logic [XLEN-1:0] r1_a_i, r1_b_i, r1_result_o;
  logic [XLEN-1:0] alu_a_o, alu_b_o, alu_result_i;
  logic [OP_W-1:0] alu_op_o;
  logic            alu_flag_i;
  logic            busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_op_i(r0_op_i),
    .r0_a_i(r0_a_i), .r0_b_i(r0_b_i), .r0_rsp_valid_o(r0_rsp_valid_o),
    .r0_rsp_ready_i(r0_rsp_ready_i), .r0_result_o(r0_result_o), .r0_flag_o(r0_flag_o),
    .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_op_i(r1_op_i),
    .r1_a_i(r1_a_i), .r1_b_i(r1_b_i), .r1_rsp_valid_o(r1_rsp_valid_o),
    .r1_rsp_ready_i(r1_rsp_ready_i), .r1_result_o(r1_result_o), .r1_flag_o(r1_flag_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_flag_i(alu_flag_i), .busy_o(busy_o)
  );

  // Stand-in for the shared ALU; comparisons return the flag as the result.
  always_comb begin
    alu_result_i = '0;
    alu_flag_i   = 1'b0;
    case (alu_op_o)
      ALU_ADD: alu_result_i = alu_a_o + alu_b_o;
      ALU_SUB: alu_result_i = alu_a_o - alu_b_o;
      ALU_AND: alu_result_i = alu_a_o & alu_b_o;
      ALU_OR:  alu_result_i = alu_a_o | alu_b_o;
      ALU_XOR: alu_result_i = alu_a_o ^ alu_b_o;
      ALU_SLL: alu_result_i = alu_a_o << alu_b_o[4:0];
      ALU_SRL: alu_result_i = alu_a_o >> alu_b_o[4:0];
      ALU_SRA: alu_result_i = $signed(alu_a_o) >>> alu_b_o[4:0];
      ALU_LTS: begin alu_flag_i = $signed(alu_a_o) <  $signed(alu_b_o); alu_result_i = {31'b0, alu_flag_i}; end
      ALU_LTU: begin alu_flag_i = alu_a_o <  alu_b_o; alu_result_i = {31'b0, alu_flag_i}; end
      ALU_GES: begin alu_flag_i = $signed(alu_a_o) >= $signed(alu_b_o); alu_result_i = {31'b0, alu_flag_i}; end
      ALU_GEU: begin alu_flag_i = alu_a_o >= alu_b_o; alu_result_i = {31'b0, alu_flag_i}; end
      ALU_EQ:  begin alu_flag_i = alu_a_o == alu_b_o; alu_result_i = {31'b0, alu_flag_i}; end
      ALU_NE:  begin alu_flag_i = alu_a_o != alu_b_o; alu_result_i = {31'b0, alu_flag_i}; end
      default: alu_result_i = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin r0_valid_i = 1'b1; r0_op_i = op; r0_a_i = a; r0_b_i = b; end
    else        begin r1_valid_i = 1'b1; r1_op_i = op; r1_a_i = a; r1_b_i = b; end
  endtask

  // Bounded wait for ready on port k; starts just after a negedge.
  task automatic wait_ready(input int k, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      got = (k == 0) ? r0_ready_o : r1_ready_o;
      if (!got) @(negedge clk_i);
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  // Ready is high now: accept at the next edge, check EXEC, then check the RESP cycle.
  task automatic accept_and_check(input int k, input logic [31:0] a, input logic [31:0] exp_res,
                                  input logic exp_flag, input string tag);
    @(posedge clk_i);
    @(negedge clk_i);
    if (k == 0) r0_valid_i = 1'b0; else r1_valid_i = 1'b0;
    chk({tag, "/exec_busy"}, {31'b0, busy_o}, 32'd1);
    chk({tag, "/alu_a"}, alu_a_o, a);
    chk({tag, "/no_rsp_in_exec"}, {31'b0, (k == 0) ? r0_rsp_valid_o : r1_rsp_valid_o}, 32'd0);
    @(negedge clk_i);
    chk({tag, "/rsp_valid"}, {31'b0, (k == 0) ? r0_rsp_valid_o : r1_rsp_valid_o}, 32'd1);
    chk({tag, "/other_rsp"}, {31'b0, (k == 0) ? r1_rsp_valid_o : r0_rsp_valid_o}, 32'd0);
    chk({tag, "/result"}, (k == 0) ? r0_result_o : r1_result_o, exp_res);
    chk({tag, "/flag"}, {31'b0, (k == 0) ? r0_flag_o : r1_flag_o}, {31'b0, exp_flag});
  endtask

  initial begin
    rstn_i = 1'b0;
    r0_valid_i = 1'b0; r0_op_i = '0; r0_a_i = '0; r0_b_i = '0; r0_rsp_ready_i = 1'b0;
    r1_valid_i = 1'b0; r1_op_i = '0; r1_a_i = '0; r1_b_i = '0; r1_rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // reset state
    chk("rst/busy", {31'b0, busy_o}, 32'd0);
    chk("rst/alu_a", alu_a_o, 32'd0);
    chk("rst/alu_op", {27'b0, alu_op_o}, 32'd0);
    chk("rst/rsp0", {31'b0, r0_rsp_valid_o}, 32'd0);
    chk("rst/rsp1", {31'b0, r1_rsp_valid_o}, 32'd0);
    rstn_i = 1'b1;

    // single ADD on port 0
    cmd(0, ALU_ADD, 32'd5, 32'd7);
    r0_rsp_ready_i = 1'b1;
    #1;
    chk("add/r0_ready", {31'b0, r0_ready_o}, 32'd1);
    chk("add/r1_ready", {31'b0, r1_ready_o}, 32'd0);
    accept_and_check(0, 32'd5, 32'd12, 1'b0, "add");
    @(negedge clk_i);
    chk("add/idle", {31'b0, busy_o}, 32'd0);
    chk("add/rsp_drop", {31'b0, r0_rsp_valid_o}, 32'd0);
    chk("add/result_hold", r0_result_o, 32'd12);

    // contention right after reset: r0 first, then r1
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    cmd(0, ALU_SUB, 32'd10, 32'd3);
    cmd(1, ALU_XOR, 32'hF0, 32'h0F);
    r1_rsp_ready_i = 1'b1;
    #1;
    chk("rr1/r0_ready", {31'b0, r0_ready_o}, 32'd1);
    chk("rr1/r1_ready", {31'b0, r1_ready_o}, 32'd0);
    accept_and_check(0, 32'd10, 32'd7, 1'b0, "rr1_sub");
    @(negedge clk_i);
    #1;
    chk("rr1/r1_ready", {31'b0, r1_ready_o}, 32'd1);
    accept_and_check(1, 32'hF0, 32'hFF, 1'b0, "rr1_xor");
    @(negedge clk_i);
    chk("rr1/idle", {31'b0, busy_o}, 32'd0);

    // both valid again: last winner was r1, so r0 is granted
    cmd(0, ALU_ADD, 32'd1, 32'd2);
    cmd(1, ALU_ADD, 32'd3, 32'd4);
    #1;
    chk("rr2/r0_ready", {31'b0, r0_ready_o}, 32'd1);
    chk("rr2/r1_ready", {31'b0, r1_ready_o}, 32'd0);
    accept_and_check(0, 32'd1, 32'd3, 1'b0, "rr2");
    @(negedge clk_i);
    r1_valid_i = 1'b0;

    // r1 signed compare with a stalled response; r0 waits
    cmd(1, ALU_LTS, 32'hFFFF_FFFF, 32'd1);
    cmd(0, ALU_SRA, 32'h8000_0000, 32'd4);
    r1_rsp_ready_i = 1'b0;
    #1;
    chk("lts/r1_ready", {31'b0, r1_ready_o}, 32'd1);
    chk("lts/r0_ready", {31'b0, r0_ready_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    r1_valid_i = 1'b0;
    chk("lts/exec_r0_ready", {31'b0, r0_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("lts/rsp_valid", {31'b0, r1_rsp_valid_o}, 32'd1);
      chk("lts/result", r1_result_o, 32'd1);
      chk("lts/flag", {31'b0, r1_flag_o}, 32'd1);
      chk("lts/r0_blocked", {31'b0, r0_ready_o}, 32'd0);
    end
    r1_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("lts/rsp_drop", {31'b0, r1_rsp_valid_o}, 32'd0);
    chk("lts/result_hold", r1_result_o, 32'd1);
    chk("lts/r0_ready_after", {31'b0, r0_ready_o}, 32'd1);
    accept_and_check(0, 32'h8000_0000, 32'hF800_0000, 1'b0, "sra");
    @(negedge clk_i);
    cmd(0, ALU_GEU, 32'd3, 32'd3);
    #1;
    chk("geu/r0_ready", {31'b0, r0_ready_o}, 32'd1);
    accept_and_check(0, 32'd3, 32'd1, 1'b1, "geu");
    @(negedge clk_i);

    // reset during EXEC drops the transaction
    cmd(0, ALU_ADD, 32'd9, 32'd9);
    #1;
    chk("rstx/r0_ready", {31'b0, r0_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    r0_valid_i = 1'b0;
    chk("rstx/in_exec", {31'b0, busy_o}, 32'd1);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    chk("rstx/busy", {31'b0, busy_o}, 32'd0);
    chk("rstx/rsp0", {31'b0, r0_rsp_valid_o}, 32'd0);
    chk("rstx/alu_a", alu_a_o, 32'd0);
    chk("rstx/alu_b", alu_b_o, 32'd0);
    chk("rstx/alu_op", {27'b0, alu_op_o}, 32'd0);
    chk("rstx/result_clr", r0_result_o, 32'd0);
    @(negedge clk_i);
    chk("rstx/no_late_rsp", {31'b0, r0_rsp_valid_o}, 32'd0);
    cmd(1, ALU_ADD, 32'd1, 32'd1);
    wait_ready(1, "rstx/r1_ready_wait");
    accept_and_check(1, 32'd1, 32'd2, 1'b0, "rstx_add");
    @(negedge clk_i);

    // r0 pulse during r1 RESP is never accepted
    cmd(1, ALU_ADD, 32'd5, 32'd5);
    r1_rsp_ready_i = 1'b0;
    #1;
    chk("pulse/r1_ready", {31'b0, r1_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    r1_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pulse/r1_rsp", {31'b0, r1_rsp_valid_o}, 32'd1);
    chk("pulse/r1_result", r1_result_o, 32'd10);
    cmd(0, ALU_ADD, 32'd7, 32'd7);
    #1;
    chk("pulse/r0_ready", {31'b0, r0_ready_o}, 32'd0);
    @(negedge clk_i);
    r0_valid_i = 1'b0;
    chk("pulse/still_resp", {31'b0, r1_rsp_valid_o}, 32'd1);
    r1_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("pulse/idle", {31'b0, busy_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("pulse/no_r0_rsp", {31'b0, r0_rsp_valid_o}, 32'd0);
      chk("pulse/stay_idle", {31'b0, busy_o}, 32'd0);
    end
    chk("pulse/r0_result_unchanged", r0_result_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the core execute stage, port 1 is the CSR/debug unit.
- Arbitrates round-robin and registers the operands into the ALU.
- Captures the ALU result and flag, then returns them to the winning requester over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU itself stays a separate module driven through the alu_* ports.

Parameters:
- XLEN, 32, operand/result width
- OP_W, 5, ALU operation code width (matches the ALU_* opcode macros in defines.v)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- r0_valid_i  in  1  requester 0 command valid
- r0_ready_o  out  1  requester 0 command accepted
- r0_op_i  in  OP_W  requester 0 ALU operation
- r0_a_i, r0_b_i  in  XLEN  requester 0 operands
- r0_rsp_valid_o  out  1  requester 0 response valid
- r0_rsp_ready_i  in  1  requester 0 response consumed
- r0_result_o  out  XLEN  requester 0 result
- r0_flag_o  out  1  requester 0 comparison flag
- r1_*  same set as r0_*  requester 1
- alu_a_o, alu_b_o  out  XLEN  operands to the shared ALU
- alu_op_o  out  OP_W  operation to the shared ALU
- alu_result_i  in  XLEN  ALU result
- alu_flag_i  in  1  ALU flag
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rstn_i low at a rising edge): at the next edge all outputs and registers go to 0.
  - State goes to IDLE.
  - last_grant goes to 1, so requester 0 wins the first contention.
  - A reset mid-transaction discards that transaction; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted.
  - If both are high, the requester != last_grant is granted.
  - rK_ready_o = (state==IDLE) && grant==K. At most one ready is high at a time.
  - On valid&&ready: latch op, a and b into the operand registers, latch owner = K, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_*_o are driven from the operand registers; the ALU settles combinationally.
  - At the clock edge, capture alu_result_i and alu_flag_i into the response registers, then go to RESP.
- RESP:
  - r<owner>_rsp_valid_o = 1; the other requester's rsp_valid stays 0.
  - Result and flag are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: last_grant = owner, go to IDLE.
- Latency and throughput:
  - Accept at edge N; rsp_valid visible in the cycle after edge N+1.
  - With rsp_ready held high, one operation per 3 cycles.
- Outside RESP, rK_result_o and rK_flag_o hold their last captured value; only rsp_valid qualifies them.
- alu_*_o always reflect the operand registers; they are 0 after reset.
- Requester rules: command fields must stay stable while valid && !ready. Dropping valid before acceptance is legal and withdraws the command.
- Boundary conditions:
  - A requester may assert valid while its own response is pending. It is not granted until the FSM returns to IDLE.
  - The flag is passed through unmodified; the ALU forces it to 0 for non-comparison ops.
  - Undefined opcodes are forwarded as-is, and whatever the ALU returns is passed back.
  - Arithmetic wrap-around is the ALU's concern; the arbiter adds no width changes.

Decomposition:
- Opcode macros (ALU_ADD ... ALU_NE) and XLEN/OP_W defaults live in defines.v; the arbiter includes it.
- FSM state encodings become localparams in defines.v (ARB_IDLE, ARB_EXEC, ARB_RESP) so the core and the bench share them.
- Natural sub-module: rr_arbiter2 (two requests, last_grant in, one-hot grant out, purely combinational). It is reused later for memory-port sharing.

Test Plan:
- r0: ALU_ADD, a=5, b=7, rsp_ready high -> r0_rsp_valid high 2 cycles after accept, r0_result=12, r0_flag=0, back to IDLE the next cycle.
- Both valid right after reset: r0 SUB 10-3, r1 XOR 0xF0^0x0F -> r0 served first (result 7), then r1 (result 0xFF). Both valid again -> r0 granted, since last_grant=1.
- r1: ALU_LTS, a=0xFFFFFFFF, b=1, r1_rsp_ready low for 4 cycles -> result=1 and flag=1 held stable. r0_ready stays 0 throughout even with r0_valid high. r0 is accepted 1 cycle after the r1 handshake.
- r0: ALU_SRA, a=0x80000000, b=4 -> result=0xF8000000, flag=0. Then ALU_GEU, a=3, b=3 -> result=1, flag=1.
- Reset asserted during EXEC -> next edge: busy_o=0, no rsp_valid, alu_*_o=0. A fresh r1 ADD 1+1 returns 2.
- r0_valid pulsed for one cycle while the FSM is in RESP for r1 -> r0 is never accepted and no spurious response appears.
